// File: rtl/jt10_adpcm_rom_arb.sv
// rtl/jt10_adpcm_rom_arb.sv - ADPCM-A/ADPCM-B sample ROM arbiter with one-entry caches
module jt10_adpcm_rom_arb #(
  parameter int BWAIT = 4,
  parameter int AW_A  = 20,
  parameter int AW_B  = 24
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            a_req,
  input  logic [AW_A-1:0] a_addr,
  output logic [7:0]      a_data,
  output logic            a_ok,
  input  logic            b_req,
  input  logic [AW_B-1:0] b_addr,
  output logic [7:0]      b_data,
  output logic            b_ok,
  input  logic            b_flush,
  output logic [23:0]     rom_addr,
  output logic            rom_cs,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Latched requests
  logic            pend_a, pend_b;
  logic [AW_A-1:0] a_lat;
  logic [AW_B-1:0] b_lat;

  // One-entry caches: tag, data byte, valid
  logic [AW_A-1:0] a_tag;
  logic [AW_B-1:0] b_tag;
  logic [7:0]      a_cdata, b_cdata;
  logic            a_valid, b_valid;

  // Current ROM access owner: 0 = A, 1 = B
  logic            owner_b;
  logic [3:0]      starve_cnt;

  logic grant_a, grant_b;
  logic rom_done, a_fill, b_fill;
  logic a_tag_match, b_tag_match;
  logic a_hit, a_miss, b_live, b_hit, b_miss;
  logic starve_full;

  assign rom_done    = (state == WAIT) && rom_ok;
  assign a_fill      = rom_done && !owner_b;
  assign b_fill      = rom_done && owner_b;
  assign starve_full = (starve_cnt == 4'(BWAIT));

  // A hit is held off while the same side's fill lands so both never pulse
  // a_ok together; the request is re-evaluated against the new tag next cycle.
  assign a_tag_match = a_valid && (a_tag == a_lat);
  assign a_hit       = pend_a && a_tag_match && !a_fill;
  assign a_miss      = pend_a && !a_tag_match;

  // b_flush drops the pending B request for this cycle
  assign b_live      = pend_b && !b_flush;
  assign b_tag_match = b_valid && (b_tag == b_lat);
  assign b_hit       = b_live && b_tag_match && !b_fill;
  assign b_miss      = b_live && !b_tag_match;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and grant decision: A first unless B has waited BWAIT grants
  always_comb begin
    state_nx = state;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    case (state)
      IDLE: begin
        if (b_miss && (!a_miss || starve_full)) begin
          grant_b  = 1'b1;
          state_nx = SETTLE;
        end else if (a_miss) begin
          grant_a  = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE:  state_nx = WAIT;
      WAIT:    if (rom_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ROM port drive and access ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_cs   <= 1'b0;
      owner_b  <= 1'b0;
    end else begin
      if (grant_a) begin
        rom_addr <= 24'(a_lat);
        rom_cs   <= 1'b1;
        owner_b  <= 1'b0;
      end else if (grant_b) begin
        rom_addr <= 24'(b_lat);
        rom_cs   <= 1'b1;
        owner_b  <= 1'b1;
      end else if (rom_done) begin
        rom_cs   <= 1'b0;
      end
    end
  end

  // B starvation counter: counts A grants while B waits, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       starve_cnt <= '0;
    else if (grant_b || !pend_b)      starve_cnt <= '0;
    else if (grant_a && !starve_full) starve_cnt <= starve_cnt + 4'd1;
  end

  // A side: request latch, cache and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a  <= 1'b0;
      a_lat   <= '0;
      a_tag   <= '0;
      a_cdata <= '0;
      a_valid <= 1'b0;
      a_data  <= '0;
      a_ok    <= 1'b0;
    end else begin
      if (a_req) begin
        pend_a <= 1'b1;
        a_lat  <= a_addr;
      end else if (a_hit || grant_a) begin
        pend_a <= 1'b0;
      end
      a_ok <= a_hit || a_fill;
      if (a_fill) begin
        a_data  <= rom_data;
        a_cdata <= rom_data;
        a_tag   <= rom_addr[AW_A-1:0];
        a_valid <= 1'b1;
      end else if (a_hit) begin
        a_data  <= a_cdata;
      end
    end
  end

  // B side: request latch, flushable cache and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_b  <= 1'b0;
      b_lat   <= '0;
      b_tag   <= '0;
      b_cdata <= '0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_ok    <= 1'b0;
    end else begin
      if (b_req) begin
        pend_b <= 1'b1;
        b_lat  <= b_addr;
      end else if (b_flush || b_hit || grant_b) begin
        pend_b <= 1'b0;
      end
      b_ok <= b_hit || b_fill;
      if (b_fill) begin
        b_data  <= rom_data;
        b_cdata <= rom_data;
        b_tag   <= rom_addr[AW_B-1:0];
      end else if (b_hit) begin
        b_data  <= b_cdata;
      end
      if (b_flush)     b_valid <= 1'b0;
      else if (b_fill) b_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// tb/tb_jt10_adpcm_rom_arb.sv - scoreboard bench for jt10_adpcm_rom_arb
module tb_jt10_adpcm_rom_arb;
  localparam int BWAIT = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, b_flush = 1'b0;
  logic [19:0] a_addr = '0;
  logic [23:0] b_addr = '0;
  logic [7:0]  a_data, b_data, rom_data;
  logic        a_ok, b_ok, rom_cs, rom_ok;
  logic [23:0] rom_addr;

  jt10_adpcm_rom_arb #(.BWAIT(BWAIT), .AW_A(20), .AW_B(24)) dut (
    .rst_n(rst_n), .clk(clk),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ok(a_ok),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ok(b_ok),
    .b_flush(b_flush),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  // ROM model: registered data (one cycle behind rom_addr), optional ok latency
  int          rom_lat = 0;
  logic [23:0] seen = '0;
  int          age = 0;
  logic [7:0]  model_q = '0;
  logic        force_en = 1'b0;
  logic [7:0]  force_data = '0;

  function automatic logic [7:0] f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    model_q <= f(rom_addr);
    if (rom_addr !== seen) begin
      seen <= rom_addr;
      age  <= 0;
    end else if (age < 1000) begin
      age  <= age + 1;
    end
  end

  assign rom_data = force_en ? force_data : model_q;
  assign rom_ok   = (rom_lat == 0) ? 1'b1 : ((rom_addr == seen) && (age >= rom_lat));

  int passed = 0, total = 0;
  logic [7:0]  exp_a[$], exp_b[$], got_a[$], got_b[$];
  logic [23:0] grants[$];
  logic [63:0] cs_h, aok_h, bok_h;
  int          cyc;
  logic        prev_cs = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
    a_req = 1'b0; b_req = 1'b0; b_flush = 1'b0;
  endtask

  task automatic clear_obs;
    cs_h = '0; aok_h = '0; bok_h = '0; cyc = 0;
    grants.delete(); got_a.delete(); got_b.delete();
    exp_a.delete(); exp_b.delete();
  endtask

  task automatic step;
    tick;
    if (cyc < 64) begin
      cs_h[cyc] = rom_cs; aok_h[cyc] = a_ok; bok_h[cyc] = b_ok;
    end
    if (rom_cs && !prev_cs) grants.push_back(rom_addr);
    prev_cs = rom_cs;
    if (a_ok) got_a.push_back(a_data);
    if (b_ok) got_b.push_back(b_data);
    cyc++;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) step;
  endtask

  task automatic strobe_a(input logic [19:0] ad);
    a_addr = ad; a_req = 1'b1; exp_a.push_back(f({4'h0, ad}));
  endtask

  task automatic strobe_b(input logic [23:0] ad);
    b_addr = ad; b_req = 1'b1; exp_b.push_back(f(ad));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    total++; if (rom_cs !== 1'b0) $display("FAIL reset_rom_cs: got %b need 0", rom_cs); else passed++;
    total++; if (rom_addr !== 24'h0) $display("FAIL reset_rom_addr: got %h need 0", rom_addr); else passed++;
    total++; if ({a_ok, b_ok} !== 2'b00) $display("FAIL reset_ok: got %b need 00", {a_ok, b_ok}); else passed++;
    total++; if ({a_data, b_data} !== 16'h0) $display("FAIL reset_data: got %h need 0000", {a_data, b_data}); else passed++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_miss;
    clear_obs; rom_lat = 0;
    strobe_a(20'h00123);
    observe(6);
    total++; if (grants.size() != 1 || grants[0] !== 24'h000123) $display("FAIL miss_rom_addr: got %0d grants first %h need 1 grant 000123", grants.size(), grants.size() ? grants[0] : 24'hx); else passed++;
    total++; if (cs_h[5:0] !== 6'b000110) $display("FAIL miss_rom_cs: got %b need 000110", cs_h[5:0]); else passed++;
    total++; if (aok_h[5:0] !== 6'b001000) $display("FAIL miss_a_ok: got %b need 001000", aok_h[5:0]); else passed++;
    total++; if (got_a.size() != exp_a.size()) $display("FAIL miss_a_count: got %0d need %0d", got_a.size(), exp_a.size()); else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [7:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      total++; if (g !== e) $display("FAIL miss_a_data: got %h need %h", g, e); else passed++;
    end
  endtask

  task automatic test_cache_hit;
    clear_obs; rom_lat = 0;
    strobe_a(20'h00123);
    observe(4);
    total++; if (cs_h[3:0] !== 4'b0000) $display("FAIL hit_a_rom_cs: got %b need 0000", cs_h[3:0]); else passed++;
    total++; if (aok_h[3:0] !== 4'b0010) $display("FAIL hit_a_ok: got %b need 0010", aok_h[3:0]); else passed++;
    total++; if (got_a.size() != 1 || got_a[0] !== exp_a[0]) $display("FAIL hit_a_data: got %0d items first %h need %h", got_a.size(), got_a.size() ? got_a[0] : 8'hx, exp_a[0]); else passed++;
    // B miss, then B hit, then flush with concurrent request forces a ROM access
    clear_obs;
    strobe_b(24'h400010);
    observe(6);
    total++; if (cs_h[5:0] !== 6'b000110 || bok_h[5:0] !== 6'b001000) $display("FAIL miss_b: got cs %b ok %b need 000110 001000", cs_h[5:0], bok_h[5:0]); else passed++;
    strobe_b(24'h400010);
    observe(4);
    total++; if (cs_h[9:6] !== 4'b0000 || bok_h[9:6] !== 4'b0010) $display("FAIL hit_b: got cs %b ok %b need 0000 0010", cs_h[9:6], bok_h[9:6]); else passed++;
    b_flush = 1'b1;
    strobe_b(24'h400010);
    observe(6);
    total++; if (cs_h[15:10] !== 6'b000110 || bok_h[15:10] !== 6'b001000) $display("FAIL flush_b: got cs %b ok %b need 000110 001000", cs_h[15:10], bok_h[15:10]); else passed++;
    total++; if (got_b.size() != exp_b.size()) $display("FAIL hit_b_count: got %0d need %0d", got_b.size(), exp_b.size()); else passed++;
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [7:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      total++; if (g !== e) $display("FAIL hit_b_data: got %h need %h", g, e); else passed++;
    end
  endtask

  task automatic test_starvation;
    int na, bpos, ng;
    logic [3:0] cnt_a4, cnt_b;
    clear_obs; rom_lat = 0;
    cnt_a4 = 'x; cnt_b = 'x;
    strobe_a(20'h01000);
    strobe_b(24'h800000);
    na = 1;
    for (int i = 0; i < 40; i++) begin
      ng = grants.size();
      step;
      if (grants.size() > ng) begin
        if (grants[grants.size()-1] == 24'h800000) begin
          cnt_b = dut.starve_cnt;
        end else begin
          if (grants.size() == BWAIT) cnt_a4 = dut.starve_cnt;
          if (na < 6) begin
            strobe_a(20'h01000 + 20'(na));
            na++;
          end
        end
      end
    end
    bpos = -1;
    foreach (grants[i]) if (grants[i] == 24'h800000 && bpos < 0) bpos = i;
    total++; if (bpos != BWAIT) $display("FAIL starve_b_position: got %0d need %0d", bpos, BWAIT); else passed++;
    total++; if (grants.size() != 7) $display("FAIL starve_grant_count: got %0d need 7", grants.size()); else passed++;
    total++; if (cnt_a4 !== 4'(BWAIT)) $display("FAIL starve_cnt_sat: got %0d need %0d", cnt_a4, BWAIT); else passed++;
    total++; if (cnt_b !== 4'd0) $display("FAIL starve_cnt_clear: got %0d need 0", cnt_b); else passed++;
    total++; if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) $display("FAIL starve_ok_count: got a %0d b %0d need a %0d b %0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size()); else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [7:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      total++; if (g !== e) $display("FAIL starve_a_data: got %h need %h", g, e); else passed++;
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [7:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      total++; if (g !== e) $display("FAIL starve_b_data: got %h need %h", g, e); else passed++;
    end
  endtask

  task automatic test_stale_ok;
    clear_obs; rom_lat = 0;
    a_addr = 20'h02000; a_req = 1'b1; exp_a.push_back(8'h22);
    step;
    step;
    total++; if (rom_cs !== 1'b1) $display("FAIL stale_cs: got %b need 1", rom_cs); else passed++;
    force_en = 1'b1; force_data = 8'h11;
    step;
    force_data = 8'h22;
    step;
    step;
    force_en = 1'b0;
    total++; if (aok_h[4:0] !== 5'b01000) $display("FAIL stale_ok: got %b need 01000", aok_h[4:0]); else passed++;
    total++; if (got_a.size() != 1 || got_a[0] !== exp_a[0]) $display("FAIL stale_data: got %0d items first %h need %h", got_a.size(), got_a.size() ? got_a[0] : 8'hx, exp_a[0]); else passed++;
  endtask

  task automatic test_simultaneous;
    int fa, fb;
    clear_obs; rom_lat = 3;
    strobe_a(20'h03000);
    strobe_b(24'h900000);
    observe(30);
    fa = -1; fb = -1;
    for (int i = 0; i < 30; i++) begin
      if (aok_h[i] && fa < 0) fa = i;
      if (bok_h[i] && fb < 0) fb = i;
    end
    total++; if (grants.size() != 2 || grants[0] !== 24'h003000 || grants[1] !== 24'h900000) $display("FAIL simul_order: got %0d grants need 003000 then 900000", grants.size()); else passed++;
    total++; if (!(fa >= 0 && fb > fa)) $display("FAIL simul_ok_order: got a at %0d b at %0d need a before b", fa, fb); else passed++;
    total++; if ($countones(aok_h) != 1 || $countones(bok_h) != 1) $display("FAIL simul_pulse: got a %0d b %0d pulses need 1 1", $countones(aok_h), $countones(bok_h)); else passed++;
    total++; if (got_a.size() != 1 || got_a[0] !== exp_a[0]) $display("FAIL simul_a_data: got %0d items first %h need %h", got_a.size(), got_a.size() ? got_a[0] : 8'hx, exp_a[0]); else passed++;
    total++; if (got_b.size() != 1 || got_b[0] !== exp_b[0]) $display("FAIL simul_b_data: got %0d items first %h need %h", got_b.size(), got_b.size() ? got_b[0] : 8'hx, exp_b[0]); else passed++;
  endtask

  task automatic test_reset_mid;
    clear_obs; rom_lat = 6;
    a_addr = 20'h04000; a_req = 1'b1;
    observe(4);
    total++; if (rom_cs !== 1'b1) $display("FAIL midrst_pre_cs: got %b need 1", rom_cs); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({rom_cs, a_ok, b_ok} !== 3'b000) $display("FAIL midrst_outputs: got %b need 000", {rom_cs, a_ok, b_ok}); else passed++;
    tick; tick;
    rst_n = 1'b1; rom_lat = 0;
    clear_obs;
    observe(8);
    total++; if (aok_h[7:0] !== 8'h0 || bok_h[7:0] !== 8'h0 || cs_h[7:0] !== 8'h0) $display("FAIL midrst_quiet: got a %b b %b cs %b need zeros", aok_h[7:0], bok_h[7:0], cs_h[7:0]); else passed++;
    clear_obs;
    strobe_a(20'h00123);
    observe(6);
    total++; if (cs_h[5:0] !== 6'b000110 || aok_h[5:0] !== 6'b001000) $display("FAIL midrst_a_miss: got cs %b ok %b need 000110 001000", cs_h[5:0], aok_h[5:0]); else passed++;
    total++; if (got_a.size() != 1 || got_a[0] !== exp_a[0]) $display("FAIL midrst_a_data: got %0d items first %h need %h", got_a.size(), got_a.size() ? got_a[0] : 8'hx, exp_a[0]); else passed++;
    clear_obs;
    strobe_b(24'h400010);
    observe(6);
    total++; if (cs_h[5:0] !== 6'b000110 || bok_h[5:0] !== 6'b001000) $display("FAIL midrst_b_miss: got cs %b ok %b need 000110 001000", cs_h[5:0], bok_h[5:0]); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_miss;
    test_cache_hit;
    test_starvation;
    test_stale_ok;
    test_simultaneous;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jt10_adpcm_rom_arb.md
Name: jt10_adpcm_rom_arb

Overview:
Shares the single external ADPCM sample ROM port between the ADPCM-A fetch path and the ADPCM-B counter/decoder chain. Requesters post single-cycle read strobes with a byte address. The arbiter serialises them onto the ROM port, returns data with a one-cycle ok pulse, and short-circuits repeat reads of the same byte through a per-requester one-entry cache (each byte holds two nibbles, so every byte is asked for twice). ADPCM-A has priority; ADPCM-B has a bounded-wait guarantee.

Parameters:
BWAIT, 4, max consecutive ROM grants to A while a B request is pending (1..15)
AW_A, 20, ADPCM-A byte address width
AW_B, 24, ADPCM-B byte address width (matches counter addr output)

Ports:
rst_n  input  1  asynchronous active-low reset
clk  input  1  system clock (same clk as the ADPCM-B counter; no cen used here)
a_req  input  1  ADPCM-A read strobe, one cycle
a_addr  input  AW_A  ADPCM-A byte address, sampled when a_req=1
a_data  output  8  ADPCM-A read data, held until next a_ok
a_ok  output  1  one-cycle pulse, a_data valid
b_req  input  1  ADPCM-B read strobe, one cycle
b_addr  input  AW_B  ADPCM-B byte address, sampled when b_req=1
b_data  output  8  ADPCM-B read data, held until next b_ok
b_ok  output  1  one-cycle pulse, b_data valid
b_flush  input  1  invalidates B cache (driven by channel restart/clr)
rom_addr  output  24  ROM byte address; A addresses zero-extended
rom_cs  output  1  ROM access active
rom_data  input  8  ROM data
rom_ok  input  1  ROM data valid for current rom_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_cs=0, rom_addr=0, a_ok=b_ok=0, a_data=b_data=0, pending flags clear, caches invalid, starvation counter 0. Any in-flight access is abandoned.
- Strobe capture: x_req=1 sets pend_x and latches x_addr. A new strobe while pend_x=1 and not yet granted overwrites the address (latest wins). A strobe during that side's own in-flight access is latched as a new pending request.
- Cache hit: if a latched request matches the valid cache tag, x_ok pulses the next cycle with the cached x_data. No ROM access, pend_x cleared. Both sides may hit in the same cycle. A hit does not count toward the starvation counter.
- b_flush=1 invalidates B cache and drops pend_b that cycle. A concurrent b_req wins and sets pend_b.
- FSM states: IDLE, SETTLE, WAIT.
- IDLE: grant pending miss. A wins unless pend_b=1 and starve_cnt==BWAIT, then B wins. On grant: rom_addr<=addr, rom_cs<=1, clear pending flag, record owner, go SETTLE.
- SETTLE: one cycle. rom_ok is ignored because it may be stale from the previous address. Go WAIT.
- WAIT: on rom_ok=1, owner x_data<=rom_data, x_ok=1 (next cycle), cache tag<=rom_addr, valid=1, rom_cs<=0, go IDLE. rom_addr holds. No timeout; waits indefinitely.
- Starve counter: increments on each A grant while pend_b=1, saturating at BWAIT. Clears on any B grant or when pend_b=0.
- Minimum miss latency: strobe to ok = 4 cycles (capture, grant, settle, rom_ok first sample) with rom_ok already high. Hit latency = 2 cycles after strobe.
- rom_ok outside WAIT has no effect. x_ok never asserts on two consecutive cycles from one miss.

Test Plan:
- Single miss: reset, a_req addr 0x00123, rom_ok tied 1 data 0x5A -> rom_addr=0x000123, rom_cs high 2 cycles, a_ok pulse 4 cycles after strobe, a_data=0x5A.
- Cache hit: after above, a_req 0x00123 again -> a_ok 2 cycles later, a_data=0x5A, rom_cs stays 0. Then b_flush, b_req previous B addr -> ROM access occurs.
- Starvation bound BWAIT=4: b_req 0x800000 pending, A issues back-to-back distinct misses -> exactly 4 A grants, then B granted, b_ok with rom_data, starve counter 0.
- Stale rom_ok: rom_ok held 1 across address change with data 0x11 then 0x22 on SETTLE->WAIT -> captured value is from WAIT cycle only (0x22).
- Simultaneous: a_req and b_req same cycle, both misses, rom_ok delayed 3 cycles -> A served first, B second, each ok pulse single cycle, data routed correctly.
- Reset mid-access: rst_n low during WAIT -> rom_cs=0, no ok pulses, caches invalid; after release a_req of prior address -> full ROM access (no hit).
